// File: rtl/aes_sub_shift_iter.sv
// Iterative AES SubBytes+ShiftRows stage: NumSbox bytes substituted per cycle, result held until taken.
// Latency NumCycles+1 from the accept cycle; no overlap, input stalls (in_ready_o=0) until the output handshake.
module aes_sbox (
  input  logic       dec_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0 naturally).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] base;
    r    = 8'h01;
    base = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  logic [7:0] w_inv;

  always_comb begin
    w_inv  = 8'h00;
    data_o = 8'h00;
    if (dec_i) begin
      data_o = gf_inv(rotl(data_i, 1) ^ rotl(data_i, 3) ^ rotl(data_i, 6) ^ 8'h05);
    end else begin
      w_inv  = gf_inv(data_i);
      data_o = w_inv ^ rotl(w_inv, 1) ^ rotl(w_inv, 2) ^ rotl(w_inv, 3) ^ rotl(w_inv, 4) ^ 8'h63;
    end
  end

endmodule

module aes_sub_shift_iter #(
  parameter int NumSbox = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic [1:0]   op_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] data_o
);

  localparam int NumCycles = 16 / NumSbox;
  localparam int CntW      = (NumCycles > 1) ? $clog2(NumCycles) : 1;

  generate
    if (!(NumSbox == 1 || NumSbox == 2 || NumSbox == 4 || NumSbox == 8 || NumSbox == 16)) begin : g_bad_param
      $error("aes_sub_shift_iter: NumSbox must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e         r_fsm;
  state_e         w_fsm_nxt;
  logic [127:0]   r_state;
  logic [CntW-1:0] r_cnt;
  logic           r_dec;
  logic           w_accept;
  logic           w_last;
  logic [3:0]     w_base;
  logic [7:0]     w_sb_in  [NumSbox];
  logic [7:0]     w_sb_out [NumSbox];
  logic [127:0]   w_enc;
  logic [127:0]   w_dec;

  assign w_last = (r_cnt == CntW'(NumCycles - 1));
  assign w_base = 4'(int'(r_cnt) * NumSbox);

  always_comb begin
    for (int j = 0; j < NumSbox; j++) begin
      w_sb_in[j] = r_state[{w_base + 4'(j), 3'b000} +: 8];
    end
  end

  for (genvar j = 0; j < NumSbox; j++) begin : g_sbox
    aes_sbox u_sbox (
      .dec_i  (r_dec),
      .data_i (w_sb_in[j]),
      .data_o (w_sb_out[j])
    );
  end

  // Byte (r,c) sits at index 4c+r; encrypt rotates row r left by r, decrypt right by r.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign w_enc[8*(4*c+r) +: 8] = r_state[8*(4*((c+r)%4)+r) +: 8];
      assign w_dec[8*(4*c+r) +: 8] = r_state[8*(4*((c-r+4)%4)+r) +: 8];
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    data_o      = '0;
    w_accept    = 1'b0;
    unique case (r_fsm)
      IDLE: begin
        in_ready_o = 1'b1;
        w_accept   = in_valid_i && !clear_i;
        if (in_valid_i) w_fsm_nxt = BUSY;
      end
      BUSY: begin
        if (w_last) w_fsm_nxt = DONE;
      end
      DONE: begin
        out_valid_o = 1'b1;
        data_o      = r_dec ? w_dec : w_enc;
        if (out_ready_i) w_fsm_nxt = IDLE;
      end
      default: w_fsm_nxt = IDLE;
    endcase
    if (clear_i) w_fsm_nxt = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= '0;
      r_cnt   <= '0;
      r_dec   <= 1'b0;
    end else if (clear_i) begin
      r_state <= '0;
      r_cnt   <= '0;
      r_dec   <= 1'b0;
    end else if (w_accept) begin
      r_state <= data_i;
      r_cnt   <= '0;
      r_dec   <= (op_i == 2'b10);
    end else if (r_fsm == BUSY) begin
      for (int j = 0; j < NumSbox; j++) begin
        r_state[{w_base + 4'(j), 3'b000} +: 8] <= w_sb_out[j];
      end
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_aes_sub_shift_iter.sv
// Bench for aes_sub_shift_iter with NumSbox = 4, 1 and 16 side by side, checked against a table-driven model.
module tb_aes_sub_shift_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         out_ready;
  logic [1:0]   op;
  logic [127:0] din;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic         out_valid [3];
  logic [127:0] dout      [3];

  int n_chk  = 0;
  int n_fail = 0;
  bit checking = 0;

  logic [7:0] sbox  [256];
  logic [7:0] isbox [256];

  bit           m_busy  [3];
  bit           m_valid [3];
  int           m_left  [3];
  logic [127:0] m_exp   [3];

  always #5 clk = ~clk;

  aes_sub_shift_iter #(.NumSbox(4)) u_s4 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .op_i(op),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .data_i(din),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready), .data_o(dout[0]));

  aes_sub_shift_iter #(.NumSbox(1)) u_s1 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .op_i(op),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .data_i(din),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready), .data_o(dout[1]));

  aes_sub_shift_iter #(.NumSbox(16)) u_s16 (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .op_i(op),
    .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]), .data_i(din),
    .out_valid_o(out_valid[2]), .out_ready_i(out_ready), .data_o(dout[2]));

  function automatic int ncyc(input int i);
    return (i == 0) ? 4 : (i == 1) ? 16 : 1;
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  // Classic generator walk: p steps through powers of 3, q through powers of 1/3.
  task automatic build_tables();
    logic [7:0] p;
    logic [7:0] q;
    logic [7:0] x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'b0000};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4);
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    for (int k = 0; k < 256; k++) isbox[sbox[k]] = 8'(k);
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic [1:0] o);
    logic [7:0]   s [16];
    logic [127:0] res;
    bit           dec;
    dec = (o == 2'b10);
    for (int k = 0; k < 16; k++) s[k] = dec ? isbox[d[8*k +: 8]] : sbox[d[8*k +: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[8*(4*c+r) +: 8] = s[4*((c + (dec ? 4 - r : r)) % 4) + r];
    return res;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_busy[i]  = 0;
        m_valid[i] = 0;
        m_left[i]  = 0;
      end else if (clear) begin
        m_busy[i]  = 0;
        m_valid[i] = 0;
      end else if (m_valid[i]) begin
        if (out_ready) m_valid[i] = 0;
      end else if (m_busy[i]) begin
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_busy[i]  = 0;
          m_valid[i] = 1;
        end
      end else if (in_valid[i]) begin
        m_busy[i] = 1;
        m_left[i] = ncyc(i);
        m_exp[i]  = model(din, op);
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("out_valid[%0d]", i), 128'(out_valid[i]), 128'(m_valid[i]));
        chk($sformatf("in_ready[%0d]", i), 128'(in_ready[i]), 128'(!m_busy[i] && !m_valid[i]));
        chk($sformatf("data_o[%0d]", i), dout[i], m_valid[i] ? m_exp[i] : 128'h0);
      end
    end
  end

  task automatic wait_valid(input int i, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      in_valid[i] = 1'b0;
    end while (!out_valid[i] && cnt < 100);
    if (cnt >= 100) chk($sformatf("timeout[%0d]", i), 128'(out_valid[i]), 128'h1);
  endtask

  task automatic run(input int i, input logic [127:0] d, input logic [1:0] o, input int hold,
                     output logic [127:0] got);
    int cnt;
    @(negedge clk);
    din = d;
    op = o;
    in_valid[i] = 1'b1;
    out_ready = 1'b0;
    wait_valid(i, cnt);
    chk($sformatf("latency[%0d]", i), 128'(cnt), 128'(ncyc(i) + 1));
    got = dout[i];
    repeat (hold) @(negedge clk);
    chk($sformatf("hold[%0d]", i), dout[i], got);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  localparam logic [127:0] INC = 128'h0f0e0d0c0b0a09080706050403020100;

  initial begin
    logic [127:0] g;
    logic [127:0] g2;
    logic [127:0] b;
    int cnt;
    rst_n = 1'b0;
    clear = 1'b0;
    out_ready = 1'b0;
    op = 2'b01;
    din = '0;
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    build_tables();
    chk("sbox_00", 128'(sbox[8'h00]), 128'h63);
    chk("sbox_53", 128'(sbox[8'h53]), 128'hed);
    chk("isbox_63", 128'(isbox[8'h63]), 128'h00);
    checking = 1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 128'(in_ready[0]), 128'h1);
    chk("rst_data", dout[0], 128'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      run(i, 128'h0, 2'b01, (i == 0) ? 10 : 0, g);
      chk($sformatf("zero_enc[%0d]", i), g, {16{8'h63}});
      run(i, INC, 2'b01, 0, g2);
      chk($sformatf("inc_b0[%0d]", i), 128'(g2[7:0]), 128'h63);
      chk($sformatf("inc_b1[%0d]", i), 128'(g2[15:8]), 128'h6b);
      chk($sformatf("inc_b2[%0d]", i), 128'(g2[23:16]), 128'h67);
      chk($sformatf("inc_b3[%0d]", i), 128'(g2[31:24]), 128'h76);
      chk($sformatf("inc_b4[%0d]", i), 128'(g2[39:32]), 128'hf2);
      chk($sformatf("inc_b5[%0d]", i), 128'(g2[47:40]), 128'h01);
      chk($sformatf("inc_full[%0d]", i), g2, model(INC, 2'b01));
    end

    run(0, {16{8'h63}}, 2'b10, 0, g);
    chk("dec_63", g, 128'h0);
    run(0, INC, 2'b01, 0, g2);
    run(0, g2, 2'b10, 0, g);
    chk("dec_roundtrip", g, INC);
    run(0, INC, 2'b11, 0, g);
    chk("op11_as_enc", g, g2);

    // Back-to-back: second request held high through BUSY/DONE.
    b = 128'h00112233445566778899aabbccddeeff;
    @(negedge clk);
    din = INC;
    op = 2'b01;
    in_valid[0] = 1'b1;
    @(negedge clk);
    din = b;
    cnt = 0;
    while (!out_valid[0] && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_first", dout[0], model(INC, 2'b01));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_ready_after_hs", 128'(in_ready[0]), 128'h1);
    wait_valid(0, cnt);
    chk("b2b_latency", 128'(cnt), 128'(ncyc(0) + 1));
    chk("b2b_second", dout[0], model(b, 2'b01));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // clear in the second BUSY cycle together with a fresh request.
    @(negedge clk);
    din = INC;
    in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0;
    @(negedge clk);
    clear = 1'b1;
    in_valid[0] = 1'b1;
    din = b;
    @(negedge clk);
    clear = 1'b0;
    in_valid[0] = 1'b0;
    repeat (8) @(negedge clk);
    chk("clr_no_out", 128'(out_valid[0]), 128'h0);
    chk("clr_idle", 128'(in_ready[0]), 128'h1);
    run(0, INC, 2'b01, 0, g);
    chk("after_clear", g, g2);

    // Asynchronous reset mid-BUSY.
    @(negedge clk);
    din = INC;
    in_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    in_valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy_ready", 128'(in_ready[0]), 128'h1);
    chk("arst_busy_valid", 128'(out_valid[0]), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset in DONE.
    @(negedge clk);
    din = INC;
    in_valid[0] = 1'b1;
    wait_valid(0, cnt);
    chk("pre_arst_done", dout[0], g2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done_ready", 128'(in_ready[0]), 128'h1);
    chk("arst_done_valid", 128'(out_valid[0]), 128'h0);
    chk("arst_done_data", dout[0], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
